program_sequencer: RTL and testbench

Supplies the `opcode`/`operand` pair consumed by the instruction fetch stage and owns the program counter of the 3-bit core. During `init_regs` it captures a program, one 3-bit word per beat, into an internal store. It then steps through the program, honouring `halt_if` stalls and taking JNZ jumps when the fetch stage asserts `branch_predicted`. It raises `prog_done` when execution runs off the end of the program.

---
 rtl/program_sequencer_pkg.sv | 26 ++
 rtl/program_store.sv | 61 ++++++
 rtl/program_sequencer.sv | 127 ++++++++++++
 tb/tb_program_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: default geometry, opcode
// constants of the 3-bit core and the sequencer state encoding.
package program_sequencer_pkg;

    localparam int DEFAULT_PROG_DEPTH = 16;
    localparam int DEFAULT_ADDR_W     = 4;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        LDI = 3'd1,
        ADD = 3'd2,
        JNZ = 3'd3,
        SUB = 3'd4,
        LDA = 3'd5,
        STA = 3'd6,
        OUT = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/program_store.sv
// Dual-field instruction store: one opcode and one operand word per slot,
// single write port with half select, asynchronous read port.
module program_store
    import program_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = DEFAULT_PROG_DEPTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic              wr_half,
    input  logic [2:0]        wr_data,
    input  logic              clr_operands,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [2:0]        rd_opcode,
    output logic [2:0]        rd_operand
);

    logic [2:0] opcode_q  [PROG_DEPTH];
    logic [2:0] opcode_d  [PROG_DEPTH];
    logic [2:0] operand_q [PROG_DEPTH];
    logic [2:0] operand_d [PROG_DEPTH];

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
        opcode_d  = opcode_q;
        operand_d = operand_q;
        if (clr_operands) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                operand_d[i] = '0;
            end
        end
        if (wr_en) begin
            if (wr_half) begin
                operand_d[wr_idx] = wr_data;
            end else begin
                opcode_d[wr_idx] = wr_data;
            end
        end
    end

    // NOTE: the store is reset like any other flop because an empty program must read back as zeros immediately after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                opcode_q[i]  <= '0;
                operand_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    assign rd_opcode  = opcode_q[rd_idx];
    assign rd_operand = operand_q[rd_idx];

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: captures a program during init_regs, then walks the PC
// with stall and JNZ redirect, flagging prog_done when execution runs off the end.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = DEFAULT_PROG_DEPTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_regs,
    input  logic              load_valid,
    input  logic [2:0]        load_data,
    input  logic              halt_if,
    input  logic              branch_predicted,
    output logic [2:0]        opcode,
    output logic [2:0]        operand,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   prog_len,
    output logic              prog_done,
    output logic              load_overflow
);

    localparam logic [ADDR_W+1:0] WPTR_FULL = (ADDR_W+2)'(2 * PROG_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W+1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              overflow_q, overflow_d;

    logic              wr_en;
    logic              clr_operands;
    logic [ADDR_W+1:0] len_round;

    // Words are counted, so rounding up to whole instructions is (wptr+1+1)/2.
    assign len_round = wptr_q + (ADDR_W+2)'(2);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wptr_d       = wptr_q;
        prog_len_d   = prog_len_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        clr_operands = 1'b0;

        if (init_regs) begin
            state_d = S_LOAD;
            if (state_q != S_LOAD) begin
                clr_operands = 1'b1;
                wptr_d       = '0;
                prog_len_d   = '0;
                pc_d         = '0;
                overflow_d   = 1'b0;
            end else if (load_valid) begin
                if (wptr_q == WPTR_FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    wptr_d     = wptr_q + (ADDR_W+2)'(1);
                    prog_len_d = len_round[ADDR_W+1:1];
                end
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    pc_d    = '0;
                    state_d = (prog_len_q == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (halt_if) begin
                        pc_d = pc_q;
                    end else if (branch_predicted) begin
                        // JNZ operand is a word address; drop its low bit to get the instruction index.
                        pc_d = ADDR_W'(operand[2:1]);
                    end else if (({1'b0, pc_q} + (ADDR_W+1)'(1)) == prog_len_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            pc_q       <= '0;
            wptr_q     <= '0;
            prog_len_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wptr_q     <= wptr_d;
            prog_len_q <= prog_len_d;
            overflow_q <= overflow_d;
        end
    end

    program_store #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_idx       (wptr_q[ADDR_W:1]),
        .wr_half      (wptr_q[0]),
        .wr_data      (load_data),
        .clr_operands (clr_operands),
        .rd_idx       (pc_q),
        .rd_opcode    (opcode),
        .rd_operand   (operand)
    );

    assign pc            = pc_q;
    assign prog_len      = prog_len_q;
    assign prog_done     = (state_q == S_DONE);
    assign load_overflow = overflow_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a directed vector table, corner
// sequences, and random load/run traffic against a word-list reference model.
module tb_program_sequencer;

    localparam int PD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_regs = 1'b0;
    logic          load_valid = 1'b0;
    logic [2:0]    load_data = '0;
    logic          halt_if = 1'b0;
    logic          branch_predicted = 1'b0;
    logic [2:0]    opcode;
    logic [2:0]    operand;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic          prog_done;
    logic          load_overflow;

    program_sequencer #(.PROG_DEPTH(PD), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_regs        (init_regs),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .halt_if          (halt_if),
        .branch_predicted (branch_predicted),
        .opcode           (opcode),
        .operand          (operand),
        .pc               (pc),
        .prog_len         (prog_len),
        .prog_done        (prog_done),
        .load_overflow    (load_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: program held as plain word slots plus a count of words loaded.
    localparam int PH_EMPTY = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;
    int m_op  [PD];
    int m_opd [PD];
    int m_words, m_pc, m_phase;
    bit m_ovf;

    function automatic int m_len();
        return (m_words + 1) / 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PD; i++) begin
            m_op[i]  = 0;
            m_opd[i] = 0;
        end
        m_words = 0;
        m_pc    = 0;
        m_phase = PH_EMPTY;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit init, input bit lv, input int d, input bit halt, input bit br);
        if (init) begin
            if (m_phase != PH_LOAD) begin
                m_phase = PH_LOAD;
                m_words = 0;
                m_ovf   = 1'b0;
                m_pc    = 0;
                for (int i = 0; i < PD; i++) m_opd[i] = 0;
            end else if (lv) begin
                if (m_words == 2 * PD) begin
                    m_ovf = 1'b1;
                end else begin
                    if (m_words % 2 == 0) m_op[m_words / 2] = d;
                    else                  m_opd[m_words / 2] = d;
                    m_words++;
                end
            end
        end else if (m_phase == PH_LOAD) begin
            m_pc    = 0;
            m_phase = (m_len() == 0) ? PH_DONE : PH_RUN;
        end else if (m_phase == PH_RUN) begin
            if (halt) begin
                m_pc = m_pc;
            end else if (br) begin
                m_pc = m_opd[m_pc] / 2;
            end else if (m_pc + 1 == m_len()) begin
                m_phase = PH_DONE;
            end else begin
                m_pc = m_pc + 1;
            end
        end
    endtask

    task automatic drive(input bit init, input bit lv, input int d, input bit halt, input bit br);
        init_regs        = init;
        load_valid       = lv;
        load_data        = 3'(d);
        halt_if          = halt;
        branch_predicted = br;
        model_step(init, lv, d, halt, br);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"},       int'(pc),            m_pc);
        check({tag, "_opcode"},   int'(opcode),        m_op[m_pc]);
        check({tag, "_operand"},  int'(operand),       m_opd[m_pc]);
        check({tag, "_prog_len"}, int'(prog_len),      m_len());
        check({tag, "_done"},     int'(prog_done),     (m_phase == PH_DONE) ? 1 : 0);
        check({tag, "_overflow"}, int'(load_overflow), int'(m_ovf));
    endtask

    task automatic cyc(input bit init, input bit lv, input int d, input bit halt, input bit br, input string tag);
        drive(init, lv, d, halt, br);
        check_model(tag);
    endtask

    task automatic load_prog(input int words[$]);
        cyc(1, 0, 0, 0, 0, "ld_entry");
        foreach (words[i]) cyc(1, 1, words[i], 0, 0, "ld_beat");
    endtask

    typedef struct {
        bit init, lv;
        int data;
        bit halt, br;
        int pc, op, opd, len;
        bit done;
    } vec_t;

    function automatic vec_t mk(bit i, bit l, int d, bit h, bit b, int p, int o, int od, int ln, bit dn);
        vec_t v;
        v.init = i; v.lv = l; v.data = d; v.halt = h; v.br = b;
        v.pc = p; v.op = o; v.opd = od; v.len = ln; v.done = dn;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int prog_a[$];
        int prog_odd[$];
        int ovf_words[$];

        prog_a   = '{0, 3, 5, 4, 3, 0};
        prog_odd = '{0, 6, 3, 5, 2};
        for (int k = 0; k < 33; k++) ovf_words.push_back(k == 32 ? 7 : (k * 3 + 1) % 8);

        //           init lv d  halt br   pc op opd len done
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 3, 0, 0,   0, 0, 3, 1, 0));
        vecs.push_back(mk(1, 1, 5, 0, 0,   0, 0, 3, 2, 0));
        vecs.push_back(mk(1, 1, 4, 0, 0,   0, 0, 3, 2, 0));
        vecs.push_back(mk(1, 1, 3, 0, 0,   0, 0, 3, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,   0, 0, 3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 5, 4, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2, 3, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,   0, 0, 3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 5, 4, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,   1, 5, 4, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,   1, 5, 4, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   1, 5, 4, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2, 3, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2, 3, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2, 3, 0, 3, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0));

        model_reset();
        #2;
        check("reset_pc",       int'(pc),            0);
        check("reset_opcode",   int'(opcode),        0);
        check("reset_operand",  int'(operand),       0);
        check("reset_prog_len", int'(prog_len),      0);
        check("reset_done",     int'(prog_done),     0);
        check("reset_overflow", int'(load_overflow), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].init, vecs[i].lv, vecs[i].data, vecs[i].halt, vecs[i].br);
            check($sformatf("vec%0d_pc", i),       int'(pc),        vecs[i].pc);
            check($sformatf("vec%0d_opcode", i),   int'(opcode),    vecs[i].op);
            check($sformatf("vec%0d_operand", i),  int'(operand),   vecs[i].opd);
            check($sformatf("vec%0d_prog_len", i), int'(prog_len),  vecs[i].len);
            check($sformatf("vec%0d_done", i),     int'(prog_done), int'(vecs[i].done));
        end

        // 33 beats into a 16-instruction store: last word is dropped.
        load_prog(ovf_words);
        check("ovf_flag", int'(load_overflow), 1);
        check("ovf_len",  int'(prog_len),      16);
        cyc(0, 0, 0, 0, 0, "ovf_run");
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, "ovf_walk");
        check("ovf_done_pc", int'(pc), 15);

        // Odd-length load leaves last operand zero; JNZ operand 5 lands on pc 2.
        load_prog(prog_odd);
        check("odd_len", int'(prog_len), 3);
        cyc(0, 0, 0, 0, 0, "odd_run");
        cyc(0, 0, 0, 0, 0, "odd_step");
        check("odd_jnz_opcode", int'(opcode), 3);
        cyc(0, 0, 0, 0, 1, "odd_jump");
        check("odd_target_pc",      int'(pc),      2);
        check("odd_target_operand", int'(operand), 0);
        check("odd_target_opcode",  int'(opcode),  2);
        cyc(0, 0, 0, 0, 0, "odd_end");
        check("odd_done", int'(prog_done), 1);

        // One-cycle init pulse with no beats ends in DONE with an empty program.
        cyc(1, 0, 0, 0, 0, "pulse_load");
        cyc(0, 0, 0, 0, 0, "pulse_exit");
        check("pulse_done", int'(prog_done), 1);
        check("pulse_len",  int'(prog_len),  0);

        // init_regs beats a simultaneous branch and halt.
        load_prog(prog_a);
        cyc(0, 0, 0, 0, 0, "prio_run");
        cyc(0, 0, 0, 0, 0, "prio_step");
        cyc(1, 0, 0, 1, 1, "prio_init");
        check("prio_len", int'(prog_len), 0);

        // Asynchronous reset in the middle of RUN.
        foreach (prog_a[i]) cyc(1, 1, prog_a[i], 0, 0, "rst_beat");
        cyc(0, 0, 0, 0, 0, "rst_run");
        cyc(0, 0, 0, 0, 0, "rst_step");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",      int'(pc),        0);
        check("async_rst_opcode",  int'(opcode),    0);
        check("async_rst_operand", int'(operand),   0);
        check("async_rst_done",    int'(prog_done), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, "empty_idle");
        cyc(0, 0, 0, 0, 1, "empty_idle_br");

        // Random programs and execution traffic.
        for (int p = 0; p < 8; p++) begin
            int n;
            int placed;
            n = $urandom_range(0, 36);
            placed = 0;
            cyc(1, 0, 0, 0, 0, "rnd_entry");
            while (placed < n) begin
                bit lv;
                lv = ($urandom_range(0, 3) != 0);
                cyc(1, lv, $urandom_range(0, 7), 0, 0, "rnd_load");
                if (lv) placed++;
            end
            for (int c = 0; c < 40; c++) begin
                cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "rnd_run");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
